countdown_timer: RTL and testbench

Loadable down-counter, the decrementing counterpart of the free-running up-counter used by the simulation benches. Software or a controlling FSM loads a start value; the block then counts down one step per enabled clock, saturates at zero, and emits a single-cycle `expired` pulse on the 1→0 transition. It serves as the timeout and delay source for protocol blocks.

---
 rtl/countdown_timer.sv | 77 +++++++
 tb/tb_countdown_timer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with a single-cycle expiry pulse on the terminal 1->0 step.
// Latency: a load shows on data one cycle after the loading edge; expired is high for the cycle after the terminal step.
// Backpressure: none. load and enable are level inputs sampled on every rising edge.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   nreset     - asynchronous active-low reset
//   load       - capture load_value into the count (has priority over enable)
//   load_value - start value for the count
//   enable     - decrement the count by one on this edge
//   data       - current count (registered)
//   zero       - data == 0, decoded combinationally from the count register
//   expired    - registered one-cycle pulse when the count reaches zero by decrement
//
// Build option: define COUNTDOWN_TIMER_AUTO_RELOAD_EN to reload the last loaded
// value on the terminal step instead of stopping at zero.
module countdown_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] data,
    output logic             zero,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] terminal_cnt;
    logic             exp_q;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    // The reload register only exists when there is a reload path to feed.
    logic [WIDTH-1:0] rld;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rld <= '0;
        end else if (load) begin
            rld <= load_value;
        end
    end

    // Restart from the reload value with no idle cycle in between.
    assign terminal_cnt = rld;
`else
    // One-shot: park at zero until the next load.
    assign terminal_cnt = '0;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt   <= '0;
            exp_q <= 1'b0;
        end else if (load) begin
            // A load on the same edge as a terminal step swallows the pulse.
            cnt   <= load_value;
            exp_q <= 1'b0;
        end else if (enable && (cnt > WIDTH'(1))) begin
            cnt   <= cnt - WIDTH'(1);
            exp_q <= 1'b0;
        end else if (enable && (cnt == WIDTH'(1))) begin
            cnt   <= terminal_cnt;
            exp_q <= 1'b1;
        end else begin
            // Disabled, or already at zero: hold. Zero never wraps.
            exp_q <= 1'b0;
        end
    end

    assign data    = cnt;
    assign zero    = (cnt == '0);
    assign expired = exp_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int WIDTH = 16;

    logic             clk;
    logic             nreset;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             expired;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .load       (load),
        .load_value (load_value),
        .enable     (enable),
        .data       (data),
        .zero       (zero),
        .expired    (expired)
    );

    // Clock held idle at 0 until t=15 so reset values can be seen before any edge.
    initial begin
        clk = 1'b0;
        #15;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected count after i enabled edges following a load of n (n >= 1).
    function automatic logic [31:0] ref_cnt(input int n, input int i);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        int r;
        r = i % n;
        return (r == 0) ? n : n - r;
`else
        return (i >= n) ? 0 : n - i;
`endif
    endfunction

    function automatic logic [31:0] ref_exp(input int n, input int i);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        return (i > 0 && (i % n) == 0) ? 1 : 0;
`else
        return (i == n) ? 1 : 0;
`endif
    endfunction

    initial begin
        int pulses;
        nreset     = 1'b0;
        load       = 1'b0;
        load_value = '0;
        enable     = 1'b0;

        // Reset with clock idle
        #10;
        chk("reset_data", data, 0);
        chk("reset_zero", zero, 1);
        chk("reset_expired", expired, 0);
        #2 nreset = 1'b1;

        // One-shot: load 5 then 8 enabled edges
        load = 1'b1; load_value = 16'd5;
        step();
        chk("os_load_data", data, 5);
        chk("os_load_expired", expired, 0);
        chk("os_load_zero", zero, 0);
        load = 1'b0; enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("os_data_%0d", i), data, ref_cnt(5, i));
            chk($sformatf("os_expired_%0d", i), expired, ref_exp(5, i));
            chk($sformatf("os_zero_%0d", i), zero, (ref_cnt(5, i) == 0) ? 1 : 0);
        end

        // Priority and pause
        enable = 1'b0; load = 1'b1; load_value = 16'd3;
        step();
        chk("pp_load", data, 3);
        load = 1'b0; enable = 1'b1;
        step();
        chk("pp_dec", data, 2);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("pp_hold_%0d", i), data, 2);
            chk($sformatf("pp_hold_exp_%0d", i), expired, 0);
        end
        enable = 1'b1;
        step();
        chk("pp_resume", data, 1);
        // Load on the same edge as the terminal step: load wins, no pulse
        load = 1'b1; load_value = 16'd7;
        step();
        chk("pp_load_over_term", data, 7);
        chk("pp_load_over_term_exp", expired, 0);
        load = 1'b0; enable = 1'b0;
        step();
        chk("pp_after_exp", expired, 0);

        // Load of zero: zero=1, no pulse while enabled
        load = 1'b1; load_value = 16'd0; enable = 1'b1;
        step();
        chk("lz_data", data, 0);
        chk("lz_zero", zero, 1);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("lz_data_%0d", i), data, 0);
            chk($sformatf("lz_exp_%0d", i), expired, 0);
        end

        // Boundary: full-scale load, count all the way down
        enable = 1'b0; load = 1'b1; load_value = 16'hFFFF;
        step();
        chk("bd_load", data, 32'hFFFF);
        load = 1'b0; enable = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 65535; i++) begin
            step();
            if (expired) pulses++;
        end
        chk("bd_data_end", data, ref_cnt(65535, 65535));
        chk("bd_expired_end", expired, 1);
        chk("bd_pulses", pulses, 1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("bd_nowrap_%0d", i), data, ref_cnt(65535, 65535 + i));
            chk($sformatf("bd_nowrap_exp_%0d", i), expired, 0);
        end

        // Async reset mid-count
        enable = 1'b0; load = 1'b1; load_value = 16'd100;
        step();
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 40; i++) step();
        chk("ar_mid", data, 60);
        #2 nreset = 1'b0;
        #1;
        chk("ar_async_data", data, 0);
        chk("ar_async_zero", zero, 1);
        chk("ar_async_exp", expired, 0);
        #2 nreset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("ar_idle_%0d", i), data, 0);
            chk($sformatf("ar_idle_exp_%0d", i), expired, 0);
        end

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        // Auto-reload: load 4, 12 enabled edges, then load 0 on the 13th edge
        enable = 1'b0; load = 1'b1; load_value = 16'd4;
        step();
        load = 1'b0; enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk($sformatf("rl_data_%0d", i), data, ref_cnt(4, i));
            chk($sformatf("rl_exp_%0d", i), expired, ((i % 4) == 0) ? 1 : 0);
            chk($sformatf("rl_zero_%0d", i), zero, 0);
        end
        load = 1'b1; load_value = 16'd0;
        step();
        chk("rl_load0_zero", zero, 1);
        chk("rl_load0_exp", expired, 0);
        load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rl_stop_exp_%0d", i), expired, 0);
            chk($sformatf("rl_stop_zero_%0d", i), zero, 1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
